// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared definitions for the square-root sequencer.
// Holds the sequencer state encoding, default widths and limits, and the
// width of the completed-operation counter.
package sqrt_pkg;

    localparam int DEF_W       = 8;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 31;
    localparam int CNT_W       = 16;

    // Sequencer states: wait for work, pulse start, wait for the core to
    // raise busy, wait for busy to fall, present the result.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_ARM   = 3'd2,
        S_RUN   = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through head output.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   push, push_data write request (ignored when full) and data
//   pop             read request (ignored when empty)
//   full, empty     occupancy flags
//   head            oldest entry, valid whenever empty is 0
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Requests are qualified here so the FIFO can never overrun or underrun
    // no matter what the surrounding logic does.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointers and occupancy; a simultaneous push and pop leaves the count
    // unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/sqrt_seq.sv
// sqrt_seq: feeds operands from a valid/ready stream to an iterative square
// root core and returns its results on a valid/ready stream.
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-low reset
//   in_valid_i, in_ready_o, in_x_bi operand stream into the input FIFO
//   sq_start_o, sq_x_bo             one-cycle start pulse and operand to core
//   sq_busy_i, sq_y_bi              core busy and result (valid as busy falls)
//   res_valid_o, res_ready_i        result stream handshake
//   res_y_bo, res_err_o             result and timeout-abort marker
//   err_o                           sticky timeout flag
//   cnt_bo                          completed operations, aborts included
module sqrt_seq
    import sqrt_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     in_x_bi,
    output logic             sq_start_o,
    output logic [W-1:0]     sq_x_bo,
    input  logic             sq_busy_i,
    input  logic [W-1:0]     sq_y_bi,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [W-1:0]     res_y_bo,
    output logic             res_err_o,
    output logic             err_o,
    output logic [CNT_W-1:0] cnt_bo
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    state_t         state;
    logic [WDW-1:0] wd;
    logic           fifo_full;
    logic           fifo_empty;
    logic [W-1:0]   fifo_head;
    logic           waiting;
    logic           wd_expire;
    logic           done;
    logic           abort;
    logic           pop;

    sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .push      (in_valid_i),
        .push_data (in_x_bi),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign in_ready_o = !fifo_full;

    // The watchdog holds the number of whole cycles already spent in ARM/RUN,
    // so the edge that would complete cycle TIMEOUT is the expiry edge.
    // A core finishing on that same edge still wins over the abort.
    assign waiting   = (state == S_ARM) || (state == S_RUN);
    assign wd_expire = waiting && (wd == WD_LAST);
    assign done      = (state == S_RUN) && !sq_busy_i;
    assign abort     = wd_expire && !done;
    assign pop       = done || abort;

    // Sequencer: issue the FIFO head with a start pulse, track the core's
    // busy handshake under the watchdog, then hold the result until taken.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= S_IDLE;
            wd          <= '0;
            sq_start_o  <= 1'b0;
            sq_x_bo     <= '0;
            res_valid_o <= 1'b0;
            res_y_bo    <= '0;
            res_err_o   <= 1'b0;
            err_o       <= 1'b0;
            cnt_bo      <= '0;
        end else begin
            sq_start_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state      <= S_ISSUE;
                        sq_start_o <= 1'b1;
                        sq_x_bo    <= fifo_head;
                    end
                end
                S_ISSUE: begin
                    state <= S_ARM;
                    wd    <= '0;
                end
                S_ARM, S_RUN: begin
                    if (done) begin
                        res_y_bo    <= sq_y_bi;
                        res_err_o   <= 1'b0;
                        res_valid_o <= 1'b1;
                        cnt_bo      <= cnt_bo + 1'b1;
                        state       <= S_HOLD;
                    end else if (abort) begin
                        res_y_bo    <= '0;
                        res_err_o   <= 1'b1;
                        err_o       <= 1'b1;
                        res_valid_o <= 1'b1;
                        cnt_bo      <= cnt_bo + 1'b1;
                        state       <= S_HOLD;
                    end else begin
                        wd <= wd + 1'b1;
                        if (state == S_ARM && sq_busy_i) begin
                            state <= S_RUN;
                        end
                    end
                end
                S_HOLD: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        res_err_o   <= 1'b0;
                        if (!fifo_empty) begin
                            state      <= S_ISSUE;
                            sq_start_o <= 1'b1;
                            sq_x_bo    <= fifo_head;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_seq.sv
// tb_sqrt_seq: directed self-checking bench for sqrt_seq with a behavioural
// square-root core whose busy line can also be forced stuck high or low.
module tb_sqrt_seq;

    localparam int W = 8;
    localparam int L = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [W-1:0]  in_x_bi = '0;
    logic          sq_start_o;
    logic [W-1:0]  sq_x_bo;
    logic          sq_busy_i;
    logic [W-1:0]  sq_y_bi;
    logic          res_valid_o;
    logic          res_ready_i = 1'b0;
    logic [W-1:0]  res_y_bo;
    logic          res_err_o;
    logic          err_o;
    logic [15:0]   cnt_bo;

    int errors = 0;
    int checks = 0;

    logic          core_busy;
    logic [3:0]    core_cnt;
    logic [W-1:0]  core_y;
    int            core_mode = 0;

    sqrt_seq dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_x_bi     (in_x_bi),
        .sq_start_o  (sq_start_o),
        .sq_x_bo     (sq_x_bo),
        .sq_busy_i   (sq_busy_i),
        .sq_y_bi     (sq_y_bi),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_y_bo    (res_y_bo),
        .res_err_o   (res_err_o),
        .err_o       (err_o),
        .cnt_bo      (cnt_bo)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk_i = ~clk_i;

    function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
        for (int i = 15; i >= 0; i--) begin
            if (i * i <= int'(x)) return W'(i);
        end
        return '0;
    endfunction

    // Behavioural core: samples start, raises busy for L+1 sampled edges and
    // presents floor(sqrt(x)) throughout.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            core_busy <= 1'b0;
            core_cnt  <= '0;
            core_y    <= '0;
        end else if (sq_start_o) begin
            core_busy <= 1'b1;
            core_cnt  <= 4'(L);
            core_y    <= isqrt(sq_x_bo);
        end else if (core_busy) begin
            if (core_cnt == 0) core_busy <= 1'b0;
            else core_cnt <= core_cnt - 1'b1;
        end
    end

    // Core mode 1 models a core stuck busy, mode 2 a core that never starts.
    assign sq_busy_i = (core_mode == 1) ? 1'b1 : (core_mode == 2) ? 1'b0 : core_busy;
    assign sq_y_bi   = core_y;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyReset();
        @(negedge clk_i);
        rst_i       = 1'b0;
        in_valid_i  = 1'b0;
        res_ready_i = 1'b0;
        core_mode   = 0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    // Pushes one operand; returns right after the accepting edge with valid
    // still high so back-to-back pushes need no gap.
    task automatic applyStimulus(input logic [W-1:0] x);
        int n = 0;
        @(negedge clk_i);
        while (!in_ready_o && n < 200) begin
            in_valid_i = 1'b0;
            n++;
            @(negedge clk_i);
        end
        if (!in_ready_o) begin
            checkOutput("push_timeout", 32'(in_ready_o), 1);
            in_valid_i = 1'b0;
            return;
        end
        in_valid_i = 1'b1;
        in_x_bi    = x;
        @(posedge clk_i);
    endtask

    task automatic endPush();
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask

    // Waits (bounded) for a result at a negedge, checks it and consumes it.
    task automatic getResult(input string tag, input logic [W-1:0] exp_y, input logic exp_err);
        int n = 0;
        while (!res_valid_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput({tag, "_valid"}, 32'(res_valid_o), 1);
        checkOutput({tag, "_y"}, 32'(res_y_bo), 32'(exp_y));
        checkOutput({tag, "_err"}, 32'(res_err_o), 32'(exp_err));
        res_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Called one negedge after the push edge: checks the start pulse and the
    // number of cycles from it to res_valid_o.
    task automatic measureLatency(input logic [W-1:0] x, input int exp_lat, input string tag);
        int n = 0;
        int extra = 0;
        while (!sq_start_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput({tag, "_delay"}, 32'(n), 1);
        checkOutput({tag, "_start"}, 32'(sq_start_o), 1);
        checkOutput({tag, "_x"}, 32'(sq_x_bo), 32'(x));
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
            if (sq_start_o) extra++;
        end while (!res_valid_o && n < 100);
        checkOutput({tag, "_lat"}, 32'(n), 32'(exp_lat));
        checkOutput({tag, "_onepulse"}, 32'(extra), 0);
    endtask

    // Checks that every output sits at its reset value.
    task automatic checkResetState(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready_o), 1);
        checkOutput({tag, "_start"}, 32'(sq_start_o), 0);
        checkOutput({tag, "_sq_x"}, 32'(sq_x_bo), 0);
        checkOutput({tag, "_res_valid"}, 32'(res_valid_o), 0);
        checkOutput({tag, "_res_y"}, 32'(res_y_bo), 0);
        checkOutput({tag, "_res_err"}, 32'(res_err_o), 0);
        checkOutput({tag, "_err"}, 32'(err_o), 0);
        checkOutput({tag, "_cnt"}, 32'(cnt_bo), 0);
    endtask

    // Hard bound on the whole run.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic [W-1:0] first_y;
        int stable;
        int starts;
        int n;

        $display("[TB] reset and single operand");
        applyReset();
        checkResetState("rst");
        applyStimulus(8'd9);
        endPush();
        measureLatency(8'd9, 7, "single");
        getResult("single", 8'd3, 1'b0);
        checkOutput("single_cnt", 32'(cnt_bo), 1);

        $display("[TB] burst");
        applyReset();
        res_ready_i = 1'b1;
        fork
            begin
                applyStimulus(8'd0);
                applyStimulus(8'd255);
                applyStimulus(8'd200);
                applyStimulus(8'd16);
                endPush();
                checkOutput("burst_full", 32'(in_ready_o), 0);
                applyStimulus(8'd81);
                endPush();
            end
            begin
                @(negedge clk_i);
                getResult("burst0", 8'd0, 1'b0);
                getResult("burst1", 8'd15, 1'b0);
                getResult("burst2", 8'd14, 1'b0);
                getResult("burst3", 8'd4, 1'b0);
                getResult("burst4", 8'd9, 1'b0);
            end
        join
        checkOutput("burst_cnt", 32'(cnt_bo), 5);

        $display("[TB] backpressure");
        applyReset();
        res_ready_i = 1'b0;
        fork
            begin
                applyStimulus(8'd1);
                applyStimulus(8'd4);
                applyStimulus(8'd9);
                applyStimulus(8'd25);
                applyStimulus(8'd49);
                applyStimulus(8'd100);
                endPush();
            end
            begin
                n = 0;
                @(negedge clk_i);
                while (!res_valid_o && n < 200) begin
                    @(negedge clk_i);
                    n++;
                end
                checkOutput("bp_first_valid", 32'(res_valid_o), 1);
                first_y = res_y_bo;
                checkOutput("bp_first_y", 32'(first_y), 1);
                stable = 1;
                starts = 0;
                repeat (20) begin
                    @(negedge clk_i);
                    if (res_y_bo !== first_y || !res_valid_o) stable = 0;
                    if (sq_start_o) starts++;
                end
                checkOutput("bp_stable", 32'(stable), 1);
                checkOutput("bp_nostart", 32'(starts), 0);
                checkOutput("bp_full", 32'(in_ready_o), 0);
                getResult("bp0", 8'd1, 1'b0);
                getResult("bp1", 8'd2, 1'b0);
                getResult("bp2", 8'd3, 1'b0);
                getResult("bp3", 8'd5, 1'b0);
                getResult("bp4", 8'd7, 1'b0);
                getResult("bp5", 8'd10, 1'b0);
            end
        join
        checkOutput("bp_cnt", 32'(cnt_bo), 6);

        $display("[TB] stuck core");
        applyReset();
        core_mode = 1;
        applyStimulus(8'd50);
        endPush();
        measureLatency(8'd50, 32, "stuck");
        getResult("stuck", 8'd0, 1'b1);
        checkOutput("stuck_err_clear", 32'(res_err_o), 0);
        checkOutput("stuck_sticky", 32'(err_o), 1);
        core_mode = 0;
        res_ready_i = 1'b0;
        applyStimulus(8'd49);
        endPush();
        getResult("after_stuck", 8'd7, 1'b0);
        checkOutput("after_stuck_sticky", 32'(err_o), 1);
        checkOutput("after_stuck_cnt", 32'(cnt_bo), 2);

        $display("[TB] dead core");
        core_mode = 2;
        res_ready_i = 1'b0;
        applyStimulus(8'd77);
        endPush();
        measureLatency(8'd77, 32, "dead");
        getResult("dead", 8'd0, 1'b1);
        checkOutput("dead_cnt", 32'(cnt_bo), 3);
        core_mode = 0;

        $display("[TB] reset mid-run");
        res_ready_i = 1'b0;
        applyStimulus(8'd100);
        applyStimulus(8'd144);
        endPush();
        n = 0;
        while (!sq_start_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("mid_start", 32'(sq_start_o), 1);
        repeat (4) @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        checkResetState("mid_rst");
        @(negedge clk_i);
        rst_i = 1'b1;
        starts = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (sq_start_o) starts++;
        end
        checkOutput("mid_fifo_empty", 32'(starts), 0);
        applyStimulus(8'd64);
        endPush();
        getResult("post_reset", 8'd8, 1'b0);
        checkOutput("post_reset_cnt", 32'(cnt_bo), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
